// File: rtl/bus_fabric_pkg.sv
// bus_fabric_pkg: shared state type, default address map and helpers for the bus fabric
package bus_fabric_pkg;
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;
    localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;
    localparam logic [15:0] BASE_RAM   = 16'h0000;
    localparam logic [15:0] BASE_UART  = 16'h0040;
    localparam logic [15:0] BASE_GPIO  = 16'h0041;
    localparam logic [15:0] BASE_MULT  = 16'h0042;
    localparam logic [15:0] BASE_DIV   = 16'h0043;
    localparam logic [15:0] BASE_BCD   = 16'h0044;
    localparam logic [15:0] BASE_DPRAM = 16'h0045;
    localparam logic [15:0] BASE_SPARE = 16'h0046;
    localparam logic [127:0] SLAVE_BASE_DEF = {BASE_SPARE, BASE_DPRAM, BASE_BCD, BASE_DIV,
                                               BASE_MULT, BASE_GPIO, BASE_UART, BASE_RAM};
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/bus_addr_decoder.sv
// bus_addr_decoder: priority match of the upper address half against the slave window table
module bus_addr_decoder
    import bus_fabric_pkg::*;
#(
    parameter int               N        = 8,
    parameter logic [16*N-1:0]  BASE     = '0,
    parameter bit               DEFAULT0 = 1'b1,
    localparam int              IW       = clog2(N)
) (
    input  logic [15:0]   addr_hi,
    output logic [N-1:0]  sel,
    output logic [IW-1:0] idx,
    output logic          unmapped
);
    always_comb begin
        idx      = '0;
        unmapped = !DEFAULT0;
        // descending scan so the lowest matching index is the one left standing
        for (int j = N - 1; j >= 0; j--) begin
            if (addr_hi == BASE[16*j +: 16]) begin
                idx      = IW'(j);
                unmapped = 1'b0;
            end
        end
        sel = unmapped ? '0 : N'(1) << idx;
    end
endmodule

// File: rtl/bus_fabric.sv
// bus_fabric: FemtoRV32 bus to N slaves with wait states, access timeout and error capture
module bus_fabric
    import bus_fabric_pkg::*;
#(
    parameter int                        N_SLAVES            = 8,
    parameter logic [16*N_SLAVES-1:0]    SLAVE_BASE          = SLAVE_BASE_DEF,
    parameter logic [N_SLAVES-1:0]       SYNC_MASK           = N_SLAVES'(1),
    parameter bit                        UNMAPPED_TO_DEFAULT = 1'b1,
    parameter int                        TIMEOUT             = 16,
    parameter logic [31:0]               ERR_DATA            = ERR_DATA_DEF
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [31:0]               cpu_addr,
    input  logic [31:0]               cpu_wdata,
    input  logic [3:0]                cpu_wmask,
    input  logic                      cpu_rstrb,
    output logic [31:0]               cpu_rdata,
    output logic                      cpu_rbusy,
    output logic                      cpu_wbusy,
    output logic [N_SLAVES-1:0]       s_sel,
    output logic [N_SLAVES-1:0]       s_rstrb,
    output logic [4*N_SLAVES-1:0]     s_wmask,
    output logic [31:0]               s_wdata,
    input  logic [32*N_SLAVES-1:0]    s_rdata,
    input  logic [N_SLAVES-1:0]       s_ready,
    input  logic                      err_clr,
    output logic                      bus_err,
    output logic [31:0]               err_addr,
    output logic [7:0]                err_count
);
    localparam int IW = clog2(N_SLAVES);
    localparam int CW = clog2(TIMEOUT);

    state_t          state;
    logic [IW-1:0]   idx, rd_sel, wait_sel;
    logic            unmapped, use_q;
    logic [31:0]     rdata_q, acc_addr, err_at, sync_data, wait_data;
    logic [CW-1:0]   cnt;
    logic            idle, wr, rd, waited, ready, tmo, err_ev;

    bus_addr_decoder #(.N(N_SLAVES), .BASE(SLAVE_BASE), .DEFAULT0(UNMAPPED_TO_DEFAULT)) u_dec (
        .addr_hi (cpu_addr[31:16]),
        .sel     (s_sel),
        .idx     (idx),
        .unmapped(unmapped)
    );

    always_comb begin
        idle      = state == IDLE;
        wr        = |cpu_wmask;
        rd        = cpu_rstrb & !wr;
        waited    = !unmapped & !SYNC_MASK[idx];
        ready     = s_ready[wait_sel];
        tmo       = !ready & (cnt == CW'(TIMEOUT - 1));
        err_ev    = idle ? unmapped & (rd | wr) : tmo;
        err_at    = idle ? cpu_addr : acc_addr;
        sync_data = s_rdata[32*rd_sel +: 32];
        wait_data = s_rdata[32*wait_sel +: 32];
        cpu_rbusy = (state == RD_WAIT) | (idle & rd & waited);
        cpu_wbusy = (state == WR_WAIT) | (idle & wr & waited);
        cpu_rdata = use_q ? rdata_q : sync_data;
        s_rstrb   = s_sel & {N_SLAVES{idle & rd}};
        s_wdata   = cpu_wdata;
    end

    for (genvar i = 0; i < N_SLAVES; i++) begin : g_wm
        assign s_wmask[4*i +: 4] = cpu_wmask & {4{s_sel[i] & idle}};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            rd_sel    <= '0;
            wait_sel  <= '0;
            use_q     <= 1'b1;
            rdata_q   <= '0;
            acc_addr  <= '0;
            cnt       <= '0;
            bus_err   <= 1'b0;
            err_addr  <= '0;
            err_count <= '0;
        end else begin
            if (idle) begin
                if (rd) begin
                    rd_sel <= idx;
                    use_q  <= unmapped | waited;
                    if (unmapped) rdata_q <= ERR_DATA;
                    if (waited) state <= RD_WAIT;
                end
                if (wr & waited) state <= WR_WAIT;
                if ((rd | wr) & waited) begin
                    wait_sel <= idx;
                    acc_addr <= cpu_addr;
                    cnt      <= '0;
                end
            end else if (ready | tmo) begin
                state <= IDLE;
                if (state == RD_WAIT) rdata_q <= ready ? wait_data : ERR_DATA;
            end else begin
                cnt <= cnt + 1'b1;
            end
            // a clear in the same cycle as a new error discards that error
            if (err_clr) begin
                bus_err   <= 1'b0;
                err_count <= '0;
            end else if (err_ev) begin
                bus_err <= 1'b1;
                if (!bus_err) err_addr <= err_at;
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_bus_fabric.sv
// tb_bus_fabric: directed bench with a transaction-level expectation model checked every cycle
module tb_bus_fabric;
    localparam int          N   = 8;
    localparam int          TMO = 16;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic              clk = 1'b0, resetn = 1'b0;
    logic [31:0]       cpu_addr, cpu_wdata, cpu_rdata, s_wdata, err_addr;
    logic [3:0]        cpu_wmask;
    logic              cpu_rstrb, cpu_rbusy, cpu_wbusy, err_clr, bus_err;
    logic [N-1:0]      s_sel, s_rstrb, s_ready;
    logic [4*N-1:0]    s_wmask;
    logic [32*N-1:0]   s_rdata;
    logic [7:0]        err_count;

    logic [31:0]       d_rdata, d_wdata, d_eaddr;
    logic              d_rbusy, d_wbusy, d_err;
    logic [N-1:0]      d_sel, d_rstrb;
    logic [4*N-1:0]    d_wmask;
    logic [7:0]        d_ecnt;

    logic [31:0]       ram [0:63];
    logic [31:0]       ram_out;
    logic [31:0]       sd [N];
    int                n_strb3 = 0;

    int                checks = 0, failures = 0;
    bit                run = 1'b0;
    logic              exp_rbusy, exp_wbusy, exp_err, exp_rdv;
    logic [31:0]       exp_rdata, exp_eaddr;
    logic [7:0]        exp_ecnt;

    always #5 clk = ~clk;

    bus_fabric #(.UNMAPPED_TO_DEFAULT(1'b0)) dut (
        .clk(clk), .resetn(resetn), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_wmask(cpu_wmask), .cpu_rstrb(cpu_rstrb), .cpu_rdata(cpu_rdata),
        .cpu_rbusy(cpu_rbusy), .cpu_wbusy(cpu_wbusy), .s_sel(s_sel), .s_rstrb(s_rstrb),
        .s_wmask(s_wmask), .s_wdata(s_wdata), .s_rdata(s_rdata), .s_ready(s_ready),
        .err_clr(err_clr), .bus_err(bus_err), .err_addr(err_addr), .err_count(err_count)
    );

    bus_fabric dut_d (
        .clk(clk), .resetn(resetn), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_wmask(cpu_wmask), .cpu_rstrb(cpu_rstrb), .cpu_rdata(d_rdata),
        .cpu_rbusy(d_rbusy), .cpu_wbusy(d_wbusy), .s_sel(d_sel), .s_rstrb(d_rstrb),
        .s_wmask(d_wmask), .s_wdata(d_wdata), .s_rdata(s_rdata), .s_ready(s_ready),
        .err_clr(err_clr), .bus_err(d_err), .err_addr(d_eaddr), .err_count(d_ecnt)
    );

    // RAM slave: registered read of the strobed word
    always @(posedge clk) begin
        if (s_rstrb[0]) ram_out <= ram[cpu_addr[7:2]];
        if (s_rstrb[3]) n_strb3 <= n_strb3 + 1;
    end

    always_comb begin
        s_rdata = '0;
        for (int i = 0; i < N; i++) s_rdata[32*i +: 32] = (i == 0) ? ram_out : sd[i];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk("rbusy", {31'd0, cpu_rbusy}, {31'd0, exp_rbusy});
            chk("wbusy", {31'd0, cpu_wbusy}, {31'd0, exp_wbusy});
            chk("bus_err", {31'd0, bus_err}, {31'd0, exp_err});
            chk("err_count", {24'd0, err_count}, {24'd0, exp_ecnt});
            if (exp_err) chk("err_addr", err_addr, exp_eaddr);
            if (exp_rdv) chk("rdata", cpu_rdata, exp_rdata);
        end
    end

    task automatic model_err(input logic [31:0] a);
        if (!exp_err) exp_eaddr = a;
        exp_err = 1'b1;
        if (exp_ecnt != 8'd255) exp_ecnt = exp_ecnt + 8'd1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Access to slave 3; lat = cycle after the strobe where ready is raised, <1 or >TMO = never
    task automatic waited(input logic [31:0] a, input bit wr, input int lat, input logic [31:0] d);
        bit ok;
        int k;
        ok = lat >= 1 && lat <= TMO;
        k  = ok ? lat : TMO;
        cpu_addr = a;
        if (wr) begin
            cpu_wmask = 4'hF;
            exp_wbusy = 1'b1;
        end else begin
            cpu_rstrb = 1'b1;
            exp_rbusy = 1'b1;
            exp_rdv   = 1'b0;
        end
        for (int c = 0; c <= k; c++) begin
            s_ready[3] = (c == lat);
            sd[3]      = (c == lat) ? d : 32'h0;
            if (c == 0) begin
                #1;
                if (wr) chk("wait_wmask", s_wmask, 32'h0000F000);
                else    chk("wait_rstrb", {24'd0, s_rstrb}, 32'h08);
            end
            tick();
            cpu_rstrb = 1'b0;
            cpu_wmask = 4'h0;
        end
        s_ready[3] = 1'b0;
        sd[3]      = 32'h0;
        exp_rbusy  = 1'b0;
        exp_wbusy  = 1'b0;
        cpu_addr   = 32'h0;
        if (!wr) begin
            exp_rdata = ok ? d : ERR;
            exp_rdv   = 1'b1;
        end
        if (!ok) model_err(a);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        int nb;
        cpu_addr = '0; cpu_wdata = 32'h55AA55AA; cpu_wmask = '0; cpu_rstrb = 1'b0;
        err_clr = 1'b0; s_ready = '0; ram_out = '0;
        for (int i = 0; i < N; i++) sd[i] = 32'h0;
        for (int i = 0; i < 64; i++) ram[i] = 32'h0;
        ram[4] = 32'h12345678;
        ram[5] = 32'hCAFEF00D;
        exp_rbusy = 0; exp_wbusy = 0; exp_err = 0; exp_rdv = 1;
        exp_rdata = '0; exp_eaddr = '0; exp_ecnt = '0;
        run = 1'b1;
        repeat (2) tick();
        chk("rst_rdata", cpu_rdata, 32'h0);
        chk("rst_ecnt", {24'd0, err_count}, 32'h0);
        resetn = 1'b1;
        tick();
        // zero-wait RAM read; address moves away right after the strobe
        cpu_addr = 32'h10; cpu_rstrb = 1'b1;
        #1 chk("sync_rstrb", {24'd0, s_rstrb}, 32'h01);
        tick();
        cpu_rstrb = 1'b0; cpu_addr = 32'h00420000; exp_rdata = 32'h12345678;
        #1 chk("sync_sel_move", {24'd0, s_sel}, 32'h08);
        chk("sync_rdata", cpu_rdata, 32'h12345678);
        tick();
        cpu_addr = 32'h0;
        nb = n_strb3;
        waited(32'h00420004, 1'b0, 3, 32'h0000ABCD);
        chk("wait_rdata", cpu_rdata, 32'h0000ABCD);
        chk("strb3_once", n_strb3 - nb, 32'd1);
        waited(32'h00420008, 1'b0, TMO, 32'h00005A5A);
        chk("ready_at_limit", {31'd0, bus_err}, 32'd0);
        waited(32'h0042000C, 1'b1, 2, 32'h0);
        waited(32'h00420010, 1'b0, -1, 32'h0);
        chk("tmo_rdata", cpu_rdata, ERR);
        chk("tmo_addr", err_addr, 32'h00420010);
        chk("tmo_count", {24'd0, err_count}, 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0; exp_err = 1'b0; exp_ecnt = 8'd0;
        // unmapped write then read
        cpu_addr = 32'h00990000; cpu_wmask = 4'hF;
        #1 chk("unm_wmask", s_wmask, 32'h0);
        chk("unm_sel", {24'd0, s_sel}, 32'h0);
        chk("dflt_sel", {24'd0, d_sel}, 32'h01);
        tick();
        cpu_wmask = 4'h0; cpu_rstrb = 1'b1; model_err(32'h00990000);
        #1 chk("unm_rstrb", {24'd0, s_rstrb}, 32'h0);
        tick();
        cpu_rstrb = 1'b0; model_err(32'h00990000); exp_rdata = ERR;
        #1 chk("unm_rdata", cpu_rdata, ERR);
        chk("unm_count", {24'd0, err_count}, 32'd2);
        chk("unm_addr", err_addr, 32'h00990000);
        // simultaneous read and write: write wins, read dropped
        cpu_addr = 32'h20; cpu_wmask = 4'h3; cpu_rstrb = 1'b1;
        #1 chk("prio_rstrb", {24'd0, s_rstrb}, 32'h0);
        chk("prio_wmask", s_wmask, 32'h3);
        tick();
        cpu_wmask = 4'h0; cpu_rstrb = 1'b0;
        for (int i = 0; i < 300; i++) begin
            cpu_addr = 32'h00990000 | (i << 2); cpu_rstrb = 1'b1;
            tick();
            model_err(cpu_addr);
        end
        chk("sat_count", {24'd0, err_count}, 32'd255);
        chk("sat_addr", err_addr, 32'h00990000);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0; cpu_rstrb = 1'b0; exp_err = 1'b0; exp_ecnt = 8'd0;
        #1 chk("clr_wins_err", {31'd0, bus_err}, 32'd0);
        chk("clr_wins_cnt", {24'd0, err_count}, 32'd0);
        // reset while waiting on slave 3
        cpu_addr = 32'h00420000; cpu_rstrb = 1'b1; exp_rbusy = 1'b1; exp_rdv = 1'b0;
        tick();
        cpu_rstrb = 1'b0;
        tick();
        resetn = 1'b0; exp_rbusy = 1'b0; exp_rdata = 32'h0; exp_rdv = 1'b1;
        #1 chk("rst_mid_rbusy", {31'd0, cpu_rbusy}, 32'd0);
        chk("rst_mid_rdata", cpu_rdata, 32'h0);
        tick();
        resetn = 1'b1;
        tick();
        cpu_addr = 32'h14; cpu_rstrb = 1'b1;
        tick();
        cpu_rstrb = 1'b0; exp_rdata = 32'hCAFEF00D;
        #1 chk("post_rst_sync", cpu_rdata, 32'hCAFEF00D);
        repeat (2) tick();
        run = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
